// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: one partial product per clock, start/done
// handshake, unsigned or two's-complement operands selected per request.
module seq_mult #(
  parameter int A_W = 3,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               ready,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int P_W = A_W + B_W;
  localparam int C_W = (B_W > 1) ? $clog2(B_W) : 1;

  // Handshake: a request is accepted on a rising edge where start=1 and
  // ready=1; done is a one-cycle pulse and product stays put until the next done.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [A_W-1:0] mag_a;
  logic [B_W-1:0] mag_b;
  logic           neg;
  logic [P_W-1:0] acc;
  logic [C_W-1:0] cnt;

  logic           accept;
  logic [A_W-1:0] a_abs;
  logic [B_W-1:0] b_abs;
  logic           neg_in;
  logic [P_W-1:0] partial;
  logic [P_W-1:0] acc_next;
  logic [P_W-1:0] result;
  logic           last;

  always_comb begin
    accept   = start && ready;
    // The most negative operand negates to itself, which is its correct magnitude.
    a_abs    = (signed_mode && a[A_W-1]) ? (~a + 1'b1) : a;
    b_abs    = (signed_mode && b[B_W-1]) ? (~b + 1'b1) : b;
    neg_in   = signed_mode && (a[A_W-1] ^ b[B_W-1]);
    partial  = mag_b[cnt] ? (P_W'(mag_a) << cnt) : '0;
    acc_next = acc + partial;
    result   = neg ? (~acc_next + P_W'(1)) : acc_next;
    last     = (cnt == C_W'(B_W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      cnt     <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      neg     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mag_a <= a_abs;
        mag_b <= b_abs;
        neg   <= neg_in;
        acc   <= '0;
        cnt   <= '0;
        ready <= 1'b0;
        state <= S_BUSY;
      end else begin
        case (state)
          S_BUSY: begin
            acc <= acc_next;
            cnt <= cnt + 1'b1;
            if (last) begin
              product <= result;
              done    <= 1'b1;
              ready   <= 1'b1;
              state   <= S_DONE;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential shift-add multiplier with a start/done handshake and selectable unsigned or two's-complement operation. It generalises the fixed 3×4-bit combinational multiplier of the arithmetic exercises to arbitrary operand widths. It computes one partial product per clock, so it trades latency for area. It sits between operand registers and any consumer that can wait a fixed number of cycles for the result.

## Interface
Parameters:
- A_W, default 3: multiplicand width (≥2)
- B_W, default 4: multiplier width (≥2); also the number of iteration cycles

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- signed_mode  input  1  0 = unsigned operands, 1 = two's-complement operands; sampled at accept
- a  input  A_W  multiplicand; sampled at accept
- b  input  B_W  multiplier; sampled at accept
- ready  output  1  1 in IDLE and DONE; 0 in BUSY
- done  output  1  one-cycle pulse marking a valid new product
- product  output  A_W+B_W  result; unsigned or two's-complement per latched mode

## Operation
- The block has one clock, clk. Reset rst is synchronous and active-high.
- States:
  - IDLE: waiting for a request.
  - BUSY: iterating. An internal counter runs 0..B_W-1.
  - DONE: one cycle long.
- Accept condition: start=1 && ready=1 at a clock edge.
  - On accept, the block latches the operands and signed_mode, and moves to BUSY.
- Operand preparation at accept:
  - Unsigned mode: magnitudes are a and b zero-extended.
  - Signed mode: magnitudes are |a| and |b|, held as unsigned A_W and B_W bits. The most negative value is valid: |−2^(A_W−1)| = 2^(A_W−1) fits in A_W bits.
  - neg = a[MSB] XOR b[MSB] in signed mode; neg = 0 in unsigned mode.
- BUSY iteration k (k = 0..B_W-1):
  - If multiplier-magnitude bit k = 1, add (multiplicand-magnitude << k) into an A_W+B_W-bit accumulator.
  - This is LSB-first. There is no early termination, so latency is fixed.
- Leaving BUSY after iteration B_W-1:
  - product ← neg ? −acc : acc, using two's-complement negation truncated to A_W+B_W bits.
  - The state moves to DONE.
- DONE lasts one cycle with done=1.
  - If start=1 in DONE, a new request is accepted (back-to-back) and the state moves to BUSY. Otherwise the state moves to IDLE.
- product holds its value from the DONE cycle until the next DONE. It does not change during a following BUSY period.
- start while in BUSY is ignored: it is not queued and has no effect.
- Changes on a, b or signed_mode after accept have no effect on the current operation.
- Width rules:
  - The unsigned maximum (2^A_W−1)(2^B_W−1) fits in A_W+B_W bits.
  - The signed extreme (−2^(A_W−1))(−2^(B_W−1)) = 2^(A_W+B_W−2) fits as a positive signed A_W+B_W-bit value.
  - No overflow is possible in either mode.

## Timing
- Reset values: state=IDLE, ready=1, done=0, product=0, accumulator=0, counter=0.
- Reset during BUSY or DONE aborts the operation. The reset values appear on the cycle after the reset edge, and the aborted result is never output.
- Reset has priority over start in the same cycle.
- Cycle numbering: accept edge = cycle 0.
  - BUSY occupies cycles 1..B_W, with ready=0.
  - DONE is cycle B_W+1, with done=1, ready=1 and product valid.
  - Latency is B_W+1 cycles from accept to done. With the defaults, done is asserted 5 cycles after accept.
- Back-to-back throughput: one result every B_W+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst 2 cycles → ready=1, done=0, product=0.
- Unsigned maximum: signed_mode=0, a=3'b111, b=4'b1111, start for 1 cycle.
  - done pulses exactly 5 cycles after accept; product=7'h69 (105).
  - ready=0 for the 4 intervening cycles.
- Signed extremes and sign handling:
  - a=3'b100 (−4), b=4'b1000 (−8), signed_mode=1 → product=7'b0100000 (+32).
  - a=3'b111 (−1), b=4'b0111 (+7) → product=7'b1111001 (−7).
  - a=3'b011, b=4'b0000 → product=0.
- Start while BUSY: accept 2×3, then pulse start with a=7, b=15 in cycle 2 → only product=6 is produced. No second done follows.
- Back-to-back: hold start=1 with new operands during the DONE cycle of 5×5 (unsigned).
  - product=25 is shown with done.
  - The next done arrives 5 cycles later with the new result.
  - product stays at 25 in between.
- Reset mid-operation: assert rst in cycle 2 of a BUSY period → no done pulse; product=0, ready=1 from the next cycle. A fresh request afterwards completes normally.
